// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file access controller slice:
//   ADDR_W  - register address width (32 registers)
//   DATA_W  - register data width
//   state_t - host-access FSM states (IDLE, WAIT, ACK)
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/rf_port_mux.sv
// ---------------------------------------------------------------------------
// rf_port_mux
// Combinational source selection for the register-file write port and read
// port 2. A granted host write owns the write port; a granted host read owns
// the read-port-2 address. Otherwise the core drives both ports.
//
// Ports:
//   grantWr, grantRd              - host grants for this cycle
//   coreWrEn                      - core write enable (already stall-gated)
//   coreWrAddr, coreWrData        - core writeback fields
//   coreRd2Addr                   - core read-port-2 address
//   hostAddr, hostWdata           - host request fields
//   rfRegWrite, rfWriteAddr,
//   rfWriteData, rfRegAddr2       - register-file port inputs
// ---------------------------------------------------------------------------
module rf_port_mux #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              grantWr,
    input  logic              grantRd,
    input  logic              coreWrEn,
    input  logic [ADDR_W-1:0] coreWrAddr,
    input  logic [DATA_W-1:0] coreWrData,
    input  logic [ADDR_W-1:0] coreRd2Addr,
    input  logic [ADDR_W-1:0] hostAddr,
    input  logic [DATA_W-1:0] hostWdata,
    output logic              rfRegWrite,
    output logic [ADDR_W-1:0] rfWriteAddr,
    output logic [DATA_W-1:0] rfWriteData,
    output logic [ADDR_W-1:0] rfRegAddr2
);

    // Write port: the host replaces the core only on a write grant.
    always_comb begin
        rfRegWrite  = coreWrEn;
        rfWriteAddr = coreWrAddr;
        rfWriteData = coreWrData;
        if (grantWr) begin
            rfRegWrite  = 1'b1;
            rfWriteAddr = hostAddr;
            rfWriteData = hostWdata;
        end
    end

    // Read port 2: the host address is steered in only on a read grant.
    always_comb begin
        rfRegAddr2 = coreRd2Addr;
        if (grantRd) begin
            rfRegAddr2 = hostAddr;
        end
    end

endmodule

// File: rtl/rf_access_ctrl.sv
// ---------------------------------------------------------------------------
// rf_access_ctrl
// Shares the register file's write port and read port 2 between the core
// (priority) and a host/debug requester using a req/ack handshake. After
// STARVE_MAX waiting cycles the host is granted anyway and the core is
// stalled for that single cycle.
//
// Ports:
//   clk, rst                         - clock, async active-high reset
//   core_wr_en/addr/data             - core writeback request
//   core_rd2_en/addr                 - core read-port-2 request
//   core_stall                       - core must hold this cycle (comb)
//   host_req/we/addr/wdata           - host request, held until host_ack
//   host_ack, host_rdata             - registered completion and read data
//   rf_regWrite/writeAddr/writeData  - register-file write port
//   rf_regAddr2, rf_regData2         - register-file read port 2
// ---------------------------------------------------------------------------
module rf_access_ctrl #(
    parameter int ADDR_W     = rf_pkg::ADDR_W,
    parameter int DATA_W     = rf_pkg::DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_wr_en,
    input  logic [ADDR_W-1:0] core_wr_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    input  logic              core_rd2_en,
    input  logic [ADDR_W-1:0] core_rd2_addr,
    output logic              core_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              rf_regWrite,
    output logic [ADDR_W-1:0] rf_writeAddr,
    output logic [DATA_W-1:0] rf_writeData,
    output logic [ADDR_W-1:0] rf_regAddr2,
    input  logic [DATA_W-1:0] rf_regData2
);

    import rf_pkg::*;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state;
    state_t            nextState;
    logic [3:0]        wcnt;
    logic [3:0]        nextWcnt;
    logic              atLimit;
    logic              grantWr;
    logic              grantRd;
    logic              coreWrGated;
    logic              fwdHit;
    logic              hostAckReg;
    logic [DATA_W-1:0] hostRdataReg;

    assign atLimit = (wcnt == STARVE_LIM);

    // A host read that collides with a same-cycle core write to the same
    // register must see the new value, not the array contents.
    assign fwdHit = core_wr_en && (core_wr_addr == host_addr);

    // While stalled the core retries everything next cycle, so its write
    // must not also land now or it would be applied twice.
    assign coreWrGated = core_wr_en && !core_stall;

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= nextState;
            wcnt  <= nextWcnt;
        end
    end

    // Next-state, grant and stall decisions. The core wins the contested
    // port until the wait counter reaches the starvation limit; at that
    // point the host is granted and the core stalls if it wanted the port.
    always_comb begin
        nextState  = state;
        nextWcnt   = wcnt;
        grantWr    = 1'b0;
        grantRd    = 1'b0;
        core_stall = 1'b0;
        case (state)
            IDLE: begin
                if (host_req) begin
                    nextState = WAIT;
                    nextWcnt  = 4'd0;
                end
            end
            WAIT: begin
                if (host_we) begin
                    grantWr    = !core_wr_en || atLimit;
                    core_stall = core_wr_en && atLimit;
                end else begin
                    grantRd    = !core_rd2_en || atLimit;
                    core_stall = core_rd2_en && atLimit;
                end
                if (grantWr || grantRd) begin
                    nextState = ACK;
                    nextWcnt  = 4'd0;
                end else if (!atLimit) begin
                    nextWcnt = wcnt + 4'd1;
                end
            end
            ACK: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
                nextWcnt  = 4'd0;
            end
        endcase
    end

    // Completion pulse and read-data capture, both taken on the grant edge
    // so they appear together in the ACK cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hostAckReg   <= 1'b0;
            hostRdataReg <= '0;
        end else begin
            hostAckReg <= grantWr || grantRd;
            if (grantRd) begin
                hostRdataReg <= fwdHit ? core_wr_data : rf_regData2;
            end
        end
    end

    assign host_ack   = hostAckReg;
    assign host_rdata = hostRdataReg;

    rf_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) portMux (
        .grantWr     (grantWr),
        .grantRd     (grantRd),
        .coreWrEn    (coreWrGated),
        .coreWrAddr  (core_wr_addr),
        .coreWrData  (core_wr_data),
        .coreRd2Addr (core_rd2_addr),
        .hostAddr    (host_addr),
        .hostWdata   (host_wdata),
        .rfRegWrite  (rf_regWrite),
        .rfWriteAddr (rf_writeAddr),
        .rfWriteData (rf_writeData),
        .rfRegAddr2  (rf_regAddr2)
    );

endmodule

// File: tb/tb_rf_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rf_access_ctrl
// Directed bench for rf_access_ctrl with a behavioural 32x32 register file
// attached. Host transactions push their expected ack cycle and read data
// into a queue; a monitor pops and compares whenever host_ack is seen.
// ---------------------------------------------------------------------------
module tb_rf_access_ctrl;

    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_wr_en;
    logic [ADDR_W-1:0] core_wr_addr;
    logic [DATA_W-1:0] core_wr_data;
    logic              core_rd2_en;
    logic [ADDR_W-1:0] core_rd2_addr;
    logic              core_stall;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              rf_regWrite;
    logic [ADDR_W-1:0] rf_writeAddr;
    logic [DATA_W-1:0] rf_writeData;
    logic [ADDR_W-1:0] rf_regAddr2;
    logic [DATA_W-1:0] rf_regData2;

    typedef struct {
        logic        isRead;
        logic [31:0] rdata;
        int          ackCycle;
    } exp_t;

    exp_t        expQ[$];
    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    int          wr20Count = 0;
    logic [31:0] rfMem [32];

    always #5 clk = ~clk;

    rf_access_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .core_wr_en    (core_wr_en),
        .core_wr_addr  (core_wr_addr),
        .core_wr_data  (core_wr_data),
        .core_rd2_en   (core_rd2_en),
        .core_rd2_addr (core_rd2_addr),
        .core_stall    (core_stall),
        .host_req      (host_req),
        .host_we       (host_we),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
        .host_ack      (host_ack),
        .host_rdata    (host_rdata),
        .rf_regWrite   (rf_regWrite),
        .rf_writeAddr  (rf_writeAddr),
        .rf_writeData  (rf_writeData),
        .rf_regAddr2   (rf_regAddr2),
        .rf_regData2   (rf_regData2)
    );

    // Behavioural register file, cleared by the same reset.
    assign rf_regData2 = rfMem[rf_regAddr2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rfMem[i] <= '0;
        end else if (rf_regWrite) begin
            rfMem[rf_writeAddr] <= rf_writeData;
        end
    end

    // Edge counter used to time host acks.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wrEn, input logic [4:0] wrAddr,
                                 input logic [31:0] wrData, input logic rd2En,
                                 input logic [4:0] rd2Addr);
        core_wr_en    = wrEn;
        core_wr_addr  = wrAddr;
        core_wr_data  = wrData;
        core_rd2_en   = rd2En;
        core_rd2_addr = rd2Addr;
    endtask

    task automatic hostStart(input logic we, input logic [4:0] addr,
                             input logic [31:0] wdata, input logic expectAck,
                             input logic [31:0] expRdata, input int latency);
        exp_t e;
        if (expectAck) begin
            e.isRead   = !we;
            e.rdata    = expRdata;
            e.ackCycle = cyc + latency;
            expQ.push_back(e);
        end
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
    endtask

    // Returns at the falling edge of the ACK cycle with host_req dropped.
    task automatic hostFinish();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (host_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL host_ack timeout: got 0 expected 1 within 20 cycles");
        end
        host_req = 1'b0;
    endtask

    // Scoreboard monitor: every ack pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rf_regWrite && rf_writeAddr == 5'd20) wr20Count++;
                if (host_ack) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected host_ack at cycle %0d: got 1 expected 0", cyc);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("ack cycle", cyc, e.ackCycle);
                        if (e.isRead) checkOutput("host_rdata", host_rdata, e.rdata);
                    end
                end
            end
        end
    end

    initial begin
        int          n;
        int          stallCount;
        int          stallCycle;

        // Reset with the core driving and a host request present: the rf
        // ports must follow the core and the host must be ignored.
        rst = 1'b1;
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b0, 5'd6);
        host_req = 1'b1; host_we = 1'b1; host_addr = 5'd1; host_wdata = 32'h1;
        @(negedge clk);
        checkOutput("reset host_ack", {31'b0, host_ack}, 32'd0);
        checkOutput("reset host_rdata", host_rdata, 32'd0);
        checkOutput("reset core_stall", {31'b0, core_stall}, 32'd0);
        checkOutput("reset rf_regWrite", {31'b0, rf_regWrite}, 32'd1);
        checkOutput("reset rf_writeAddr", {27'b0, rf_writeAddr}, 32'd4);
        checkOutput("reset rf_regAddr2", {27'b0, rf_regAddr2}, 32'd6);
        tick();
        host_req = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        rst = 1'b0;
        tick();

        // Core write R5 with idle host, then R3 for the later read.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5);
        @(negedge clk);
        checkOutput("core wr en", {31'b0, rf_regWrite}, 32'd1);
        checkOutput("core wr addr", {27'b0, rf_writeAddr}, 32'd5);
        checkOutput("core wr data", rf_writeData, 32'hDEADBEEF);
        checkOutput("core rd2 addr", {27'b0, rf_regAddr2}, 32'd5);
        checkOutput("idle core_stall", {31'b0, core_stall}, 32'd0);
        tick();
        applyStimulus(1'b1, 5'd3, 32'h00000333, 1'b0, 5'd0);
        @(negedge clk);
        checkOutput("R5 contents", rfMem[5], 32'hDEADBEEF);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

        // Host write R7 with the core idle: grant in the first WAIT cycle.
        hostStart(1'b1, 5'd7, 32'h12345678, 1'b1, 32'h0, 2);
        tick();
        @(negedge clk);
        checkOutput("host wr grant en", {31'b0, rf_regWrite}, 32'd1);
        checkOutput("host wr grant addr", {27'b0, rf_writeAddr}, 32'd7);
        checkOutput("host wr grant data", rf_writeData, 32'h12345678);
        hostFinish();
        checkOutput("R7 contents", rfMem[7], 32'h12345678);
        tick();

        // Host read R3 against a core that keeps both ports busy.
        applyStimulus(1'b1, 5'd10, 32'hA5A5A5A5, 1'b1, 5'd1);
        n = cyc;
        hostStart(1'b0, 5'd3, 32'h0, 1'b1, 32'h00000333, 6);
        stallCount = 0;
        stallCycle = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) begin
                checkOutput("wait core rd2 addr", {27'b0, rf_regAddr2}, 32'd1);
                checkOutput("wait core wr en", {31'b0, rf_regWrite}, 32'd1);
            end
            if (core_stall) begin
                stallCount++;
                stallCycle = cyc;
                checkOutput("stall wr held", {31'b0, rf_regWrite}, 32'd0);
                checkOutput("stall rd2 host addr", {27'b0, rf_regAddr2}, 32'd3);
            end
        end
        checkOutput("stall count", stallCount, 32'd1);
        checkOutput("stall cycle", stallCycle, n + 5);
        hostFinish();
        checkOutput("ack core_stall", {31'b0, core_stall}, 32'd0);
        checkOutput("retry wr en", {31'b0, rf_regWrite}, 32'd1);
        checkOutput("retry wr addr", {27'b0, rf_writeAddr}, 32'd10);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();

        // Host read R9 while the core writes R9 in the grant cycle.
        hostStart(1'b0, 5'd9, 32'h0, 1'b1, 32'hCAFEF00D, 2);
        tick();
        applyStimulus(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0);
        hostFinish();
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

        // Pending host write, then reset: no ack, no write, clean retry.
        applyStimulus(1'b1, 5'd11, 32'hB0B0B0B0, 1'b0, 5'd0);
        hostStart(1'b1, 5'd12, 32'h55, 1'b0, 32'h0, 0);
        tick();
        tick();
        @(negedge clk);
        checkOutput("pending core keeps wr", {27'b0, rf_writeAddr}, 32'd11);
        rst = 1'b1;
        #1;
        checkOutput("rst mid ack", {31'b0, host_ack}, 32'd0);
        checkOutput("rst mid stall", {31'b0, core_stall}, 32'd0);
        checkOutput("rst mid passthru", {27'b0, rf_writeAddr}, 32'd11);
        tick();
        host_req = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("post-reset no ack", {31'b0, host_ack}, 32'd0);
        end
        checkOutput("R12 after reset", rfMem[12], 32'h0);
        tick();
        hostStart(1'b1, 5'd12, 32'h55, 1'b1, 32'h0, 2);
        hostFinish();
        checkOutput("R12 after retry", rfMem[12], 32'h55);
        tick();

        // Back-to-back host writes: second request raised right after ACK.
        hostStart(1'b1, 5'd20, 32'h20, 1'b1, 32'h0, 2);
        hostFinish();
        tick();
        hostStart(1'b1, 5'd21, 32'h21, 1'b1, 32'h0, 2);
        hostFinish();
        tick();
        tick();
        checkOutput("R20 contents", rfMem[20], 32'h20);
        checkOutput("R21 contents", rfMem[21], 32'h21);
        checkOutput("R20 write count", wr20Count, 32'd1);

        for (int i = 0; i < 4; i++) tick();
        checkOutput("scoreboard drained", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
